// File: rtl/dlf_pkg.sv
// rtl/dlf_pkg.sv - shared constants, next-state operation enum and modulus helpers for the DPLL loop filter
package dlf_pkg;

  localparam int unsigned DLF_WIDTH    = 20;
  localparam int unsigned DLF_K_OFFSET = 4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_CARRY,
    OP_BORROW,
    OP_CLAMP
  } dlf_op_e;

  // K = 2^(kMode + offset); MAX = K - 1
  function automatic logic [31:0] k_max(input logic [3:0] k_mode,
                                        input int unsigned k_offset = DLF_K_OFFSET);
    return (32'd1 << (32'(k_mode) + k_offset)) - 32'd1;
  endfunction

  function automatic logic [31:0] k_mid(input logic [3:0] k_mode,
                                        input int unsigned k_offset = DLF_K_OFFSET);
    return (32'd1 << (32'(k_mode) + k_offset)) >> 1;
  endfunction

endpackage

// File: rtl/dlf_if.sv
// rtl/dlf_if.sv - phase-detector/oscillator side signals of the loop filter
interface dlf_if import dlf_pkg::*; #(
  parameter int unsigned WIDTH = DLF_WIDTH
);

  logic             dirSig;
  logic             enable;
  logic [3:0]       kMode;
  logic             carry;
  logic             borrow;
  logic [WIDTH-1:0] count;

  modport master (
    output dirSig, enable, kMode,
    input  carry, borrow, count
  );

  modport slave (
    input  dirSig, enable, kMode,
    output carry, borrow, count
  );

endinterface

// File: rtl/dlf_modulus_decode.sv
// rtl/dlf_modulus_decode.sv - maps kMode to MAX/MID; with DLF_KMODE_LATCH_EN the modulus is
// latched at reset, on a carry/borrow reload, or while enable is low
module dlf_modulus_decode import dlf_pkg::*; #(
  parameter int unsigned WIDTH    = DLF_WIDTH,
  parameter int unsigned K_OFFSET = DLF_K_OFFSET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       i_kmode,
  input  logic             i_enable,
  input  logic             i_wrap,
  output logic [WIDTH-1:0] o_max,
  output logic [WIDTH-1:0] o_mid,
  output logic [WIDTH-1:0] o_wrap_mid
);

  logic [3:0] w_kmode_eff;

`ifdef DLF_KMODE_LATCH_EN
  logic [3:0] r_kmode;

  always_ff @(posedge clk) begin
    if (!reset || !i_enable || i_wrap) begin
      r_kmode <= i_kmode;
    end
  end

  // Capture cycles see the incoming modulus so the reset/idle value matches what gets latched
  assign w_kmode_eff = (!reset || !i_enable) ? i_kmode : r_kmode;
  assign o_wrap_mid  = WIDTH'(k_mid(i_kmode, K_OFFSET));
`else
  logic w_unused;

  assign w_unused    = &{1'b0, clk, reset, i_enable, i_wrap};
  assign w_kmode_eff = i_kmode;
  assign o_wrap_mid  = o_mid;
`endif

  assign o_max = WIDTH'(k_max(w_kmode_eff, K_OFFSET));
  assign o_mid = WIDTH'(k_mid(w_kmode_eff, K_OFFSET));

endmodule

// File: rtl/dlf.sv
// rtl/dlf.sv - DPLL K-counter loop filter: up/down count with carry/borrow pulses on wrap.
// Optional macro DLF_KMODE_LATCH_EN latches the modulus only at filter cycle boundaries.
module dlf import dlf_pkg::*; #(
  parameter int unsigned WIDTH    = DLF_WIDTH,
  parameter int unsigned K_OFFSET = DLF_K_OFFSET
) (
  input  logic clk,
  input  logic reset,
  dlf_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_carry;
  logic             r_borrow;

  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_mid;
  logic [WIDTH-1:0] w_wrap_mid;
  logic             w_wrap;
  dlf_op_e          w_op;

  dlf_modulus_decode #(
    .WIDTH    (WIDTH),
    .K_OFFSET (K_OFFSET)
  ) u_decode (
    .clk        (clk),
    .reset      (reset),
    .i_kmode    (bus.kMode),
    .i_enable   (bus.enable),
    .i_wrap     (w_wrap),
    .o_max      (w_max),
    .o_mid      (w_mid),
    .o_wrap_mid (w_wrap_mid)
  );

  // A shrinking modulus can leave the count above MAX; that reload wins even over hold
  always_comb begin
    w_op = OP_HOLD;
    if (r_count > w_max) begin
      w_op = OP_CLAMP;
    end else if (!bus.enable) begin
      w_op = OP_HOLD;
    end else if (!bus.dirSig) begin
      w_op = (r_count == w_max) ? OP_CARRY : OP_INC;
    end else begin
      w_op = (r_count == '0) ? OP_BORROW : OP_DEC;
    end
  end

  assign w_wrap = (w_op == OP_CARRY) || (w_op == OP_BORROW);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= w_mid;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      case (w_op)
        OP_INC:    r_count <= r_count + 1'b1;
        OP_DEC:    r_count <= r_count - 1'b1;
        OP_CARRY: begin
          r_count <= w_wrap_mid;
          r_carry <= 1'b1;
        end
        OP_BORROW: begin
          r_count  <= w_wrap_mid;
          r_borrow <= 1'b1;
        end
        OP_CLAMP:  r_count <= w_mid;
        default:   r_count <= r_count;
      endcase
    end
  end

  assign bus.count  = r_count;
  assign bus.carry  = r_carry;
  assign bus.borrow = r_borrow;

endmodule

// File: tb/tb_dlf.sv
// tb/tb_dlf.sv - self-checking bench for dlf: vector table, directed wrap/period sequences, random run vs model
module tb_dlf;

  logic clk;
  logic reset;

  dlf_if #(.WIDTH(20)) bus ();

  dlf #(
    .WIDTH    (20),
    .K_OFFSET (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: the filter's count and the pulse seen after the last edge
  longint m_count = 0;
  bit     m_carry = 0;
  bit     m_borrow = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       dir;
    logic [3:0] km;
    longint     exp_count;
    logic       exp_carry;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic model_step();
    longint k, mx, md;
    k  = longint'(1) << (int'(bus.kMode) + 4);
    mx = k - 1;
    md = k / 2;
    m_carry  = 0;
    m_borrow = 0;
    if (!reset) m_count = md;
    else if (m_count > mx) m_count = md;
    else if (!bus.enable) m_count = m_count;
    else if (!bus.dirSig) begin
      if (m_count == mx) begin m_count = md; m_carry = 1; end
      else m_count = m_count + 1;
    end else begin
      if (m_count == 0) begin m_count = md; m_borrow = 1; end
      else m_count = m_count - 1;
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".count"},  longint'(bus.count),  m_count);
    check({tag, ".carry"},  longint'(bus.carry),  longint'(m_carry));
    check({tag, ".borrow"}, longint'(bus.borrow), longint'(m_borrow));
  endtask

  task automatic drive(input logic r, input logic en, input logic dir, input logic [3:0] km);
    reset      = r;
    bus.enable = en;
    bus.dirSig = dir;
    bus.kMode  = km;
  endtask

  initial begin
    int cpos[$];
    int bpos[$];
    int any_pulse;

    drive(1'b0, 1'b0, 1'b0, 4'd1);

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd1,  16,     1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd1,  16,     1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd1,  17,     1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd1,  18,     1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd1,  17,     1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd1,  18,     1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd1,  18,     1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd2,  17,     1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  8,      1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd0,  7,      1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd3,  64,     1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd15, 65,     1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd15, 262144, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd14, 131072, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].dir, vecs[i].km);
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_count", i),  longint'(bus.count),  vecs[i].exp_count);
      check($sformatf("vec%0d.tbl_carry", i),  longint'(bus.carry),  longint'(vecs[i].exp_carry));
      check($sformatf("vec%0d.tbl_borrow", i), longint'(bus.borrow), longint'(vecs[i].exp_borrow));
    end

    // Up count from MID at K=32: carry every 16 enabled cycles
    drive(1'b0, 1'b1, 1'b0, 4'd1);
    tick("up_rst");
    drive(1'b1, 1'b1, 1'b0, 4'd1);
    cpos.delete();
    any_pulse = 0;
    for (int i = 1; i <= 40; i++) begin
      tick("up");
      if (bus.carry) cpos.push_back(i);
      if (bus.borrow) any_pulse++;
    end
    check("up.carry_first",  cpos.size() > 0 ? cpos[0] : -1, 16);
    check("up.carry_second", cpos.size() > 1 ? cpos[1] : -1, 32);
    check("up.no_borrow", any_pulse, 0);

    // Down count from MID: borrow every 17 enabled cycles
    drive(1'b0, 1'b1, 1'b1, 4'd1);
    tick("dn_rst");
    drive(1'b1, 1'b1, 1'b1, 4'd1);
    bpos.delete();
    any_pulse = 0;
    for (int i = 1; i <= 40; i++) begin
      tick("dn");
      if (bus.borrow) begin
        bpos.push_back(i);
        check("dn.count_after_borrow", longint'(bus.count), 16);
      end
      if (bus.carry) any_pulse++;
    end
    check("dn.borrow_first",  bpos.size() > 0 ? bpos[0] : -1, 17);
    check("dn.borrow_second", bpos.size() > 1 ? bpos[1] : -1, 34);
    check("dn.no_carry", any_pulse, 0);

    // Grow modulus at count 20: continue to 63, then carry period 32
    drive(1'b0, 1'b1, 1'b0, 4'd1);
    tick("km_rst");
    drive(1'b1, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 4; i++) tick("km_pre");
    check("km.count20", longint'(bus.count), 20);
    bus.kMode = 4'd2;
    cpos.delete();
    for (int i = 1; i <= 80; i++) begin
      tick("km_up");
      if (bus.carry) cpos.push_back(i);
    end
    check("km.carry_first",  cpos.size() > 0 ? cpos[0] : -1, 44);
    check("km.carry_second", cpos.size() > 1 ? cpos[1] : -1, 76);
    for (int i = 0; i < 14; i++) tick("km_to50");
    check("km.count50", longint'(bus.count), 50);
    // Shrink modulus below the count: reload to new MID, no pulse
    bus.kMode = 4'd1;
    tick("km_shrink");
    check("km.shrink_count",  longint'(bus.count), 16);
    check("km.shrink_carry",  longint'(bus.carry), 0);
    check("km.shrink_borrow", longint'(bus.borrow), 0);

    // Enable hold at 25
    for (int i = 0; i < 9; i++) tick("hold_pre");
    check("hold.count25", longint'(bus.count), 25);
    bus.enable = 1'b0;
    any_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      bus.dirSig = i[0];
      tick("hold");
      if (bus.count != 20'd25) any_pulse++;
      if (bus.carry || bus.borrow) any_pulse++;
    end
    check("hold.stable", any_pulse, 0);
    drive(1'b1, 1'b1, 1'b0, 4'd1);
    tick("hold_resume");
    check("hold.resume", longint'(bus.count), 26);

    // Toggling direction: +/-1 oscillation without pulses
    any_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      bus.dirSig = i[0];
      tick("toggle");
      if (bus.carry || bus.borrow) any_pulse++;
    end
    check("toggle.no_pulse", any_pulse, 0);

    // Reset mid-count has priority over counting
    drive(1'b0, 1'b1, 1'b0, 4'd1);
    tick("rst_mid");
    check("rst_mid.count", longint'(bus.count), 16);

    // Randomized run against the model
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      bus.enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.dirSig = ~bus.dirSig;
      if ($urandom_range(0, 31) == 0) bus.kMode = 4'($urandom_range(0, 3));
      tick("rand");
      check("rand.exclusive", longint'(bus.carry & bus.borrow), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dlf.md
Name: dlf

Overview:
- Digital loop filter (K-counter) for the DPLL, sitting between the phase detector and the digital-controlled oscillator (increment/decrement stage).
- Counts up or down according to the phase-error direction bit.
- Emits a one-cycle carry on up-overflow and a one-cycle borrow on down-underflow; each pulse steers the oscillator.
- Modulus K is programmable at run time through kMode; larger K gives a narrower loop bandwidth.

Parameters:
- WIDTH, 20, bit width of the count register and count output.
- K_OFFSET, 4, modulus exponent offset: K = 2^(kMode + K_OFFSET); must satisfy 15 + K_OFFSET < WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 clears state on the next rising clk edge).
- dirSig  input  1  phase error direction: 0 = count up, 1 = count down.
- enable  input  1  count enable; 0 = hold.
- kMode  input  4  modulus select, 0..15; K = 2^(kMode+4), range 16..524288.
- carry  output  1  registered one-cycle pulse on up-overflow.
- borrow  output  1  registered one-cycle pulse on down-underflow.
- count  output  WIDTH  current counter value, registered.

Behaviour:
- Definitions: K = 1 << (kMode + K_OFFSET); MID = K >> 1; MAX = K - 1.
- Reset (reset=0 at the clk edge): count = MID of the current kMode; carry = 0; borrow = 0. Reset has priority over all other inputs.
- enable=0: count holds; carry = 0 and borrow = 0 on that edge.
- enable=1, dirSig=0, count < MAX: count+1, carry = 0.
- enable=1, dirSig=0, count == MAX: count = MID, carry = 1 for exactly one cycle.
- enable=1, dirSig=1, count > 0: count-1, borrow = 0.
- enable=1, dirSig=1, count == 0: count = MID, borrow = 1 for exactly one cycle.
- Pulse timing: outputs are registered; the pulse appears in the cycle following the edge that detected overflow/underflow. carry and borrow are never high together.
- Resulting periods under a constant direction from MID: carry every MID enabled up-cycles; borrow every MID+1 enabled down-cycles.
- kMode change mid-operation: new K applies on the next edge.
  - If count > new MAX, count reloads to the new MID with no carry/borrow pulse.
  - Otherwise counting continues from the current value.
- dirSig toggling every cycle: count oscillates by ±1 with no pulses.
- Arithmetic: unsigned, WIDTH bits; count never exceeds MAX.

Optional Feature:
- Macro: DLF_KMODE_LATCH_EN.
- Defined: kMode is captured into an internal register only at reset, on a carry/borrow reload, or while enable=0. The modulus therefore changes only at cycle boundaries of the filter, and the mid-cycle clamp rule never fires.
- Undefined: kMode is used combinationally every cycle, per the Behaviour section.

Decomposition:
- Shared package dlf_pkg:
  - constants DLF_WIDTH=20 and DLF_K_OFFSET=4;
  - function k_max(kMode) returning MAX;
  - function k_mid(kMode) returning MID.
- One natural sub-module: dlf_modulus_decode, mapping kMode to MAX/MID (and holding the latched kMode when DLF_KMODE_LATCH_EN is defined).
- The counter and the pulse logic stay in the top level.

Test Plan:
- Reset check: reset=0, kMode=1 for several clks -> count=16, carry=0, borrow=0.
- Up count: reset=1, enable=1, dirSig=0, kMode=1 -> count 16→31, then carry=1 for one cycle with count=16; carry recurs every 16 cycles, borrow stays 0.
- Down count: dirSig=1, kMode=1, start from 16 -> count reaches 0, next edge gives borrow=1 with count=16; period 17 cycles.
- kMode change mid-run: kMode=2 (K=64) while count=20 -> counting continues to 63, carry period 32. Then kMode=1 while count=50 -> count=16 on the next edge, no pulse.
- Enable hold: enable=0 for 10 cycles at count=25 -> count stays 25, carry=borrow=0; counting resumes when enable returns to 1.
- Extreme modulus and reset priority:
  - kMode=15 -> reset value count=262144, carry after 262144 up-cycles, count never exceeds 524287.
  - Asserting reset=0 mid-count -> count=MID on the next edge.
